// File: rtl/sync_fifo.sv
// Single-clock ready/valid FIFO with first-word-fall-through read from a register array.
// Handshake outputs are registered so no combinational path exists from in_valid/out_ready.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LevelOne  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   LevelZero = '0;
  localparam logic [DEPTH_LOG2:0]   LevelFull = (DEPTH_LOG2 + 1)'(Depth);

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;

  logic push, pop;

  // Qualify with the registered flags: a full FIFO ignores in_valid even when popping.
  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase

    in_ready_d  = (level_d != LevelFull);
    out_valid_d = (level_d != LevelZero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage is enable-only; contents are meaningless until written after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign level     = level_q;

endmodule
